// File: rtl/btb_update_queue_pkg.sv
// Shared BTB package: PC geometry and the BTB update entry layout.
// Imported by the update queue, its FIFO and the branch-bus interface.
// Contents: PC_WIDTH, INST_BYTES, upd_entry_t {valid, pc, target}.
package btb_update_queue_pkg;

    localparam int PC_WIDTH   = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic                valid;
        logic [PC_WIDTH-1:0] pc;
        logic [PC_WIDTH-1:0] target;
    } upd_entry_t;

endpackage

// File: rtl/btb_update_queue_if.sv
// Resolved-branch bus from execute into the BTB update queue.
// master = execute side (drives branch info), slave = update queue (drives br_ready).
// Signals: br_valid/br_ready handshake, br_pc, br_taken, br_target, br_pred_hit, br_pred_pc.
interface btb_update_queue_if
    import btb_update_queue_pkg::*;
();
    logic                br_valid;
    logic                br_ready;
    logic [PC_WIDTH-1:0] br_pc;
    logic                br_taken;
    logic [PC_WIDTH-1:0] br_target;
    logic                br_pred_hit;
    logic [PC_WIDTH-1:0] br_pred_pc;

    modport master (
        output br_valid, br_pc, br_taken, br_target, br_pred_hit, br_pred_pc,
        input  br_ready
    );

    modport slave (
        input  br_valid, br_pc, br_taken, br_target, br_pred_hit, br_pred_pc,
        output br_ready
    );
endinterface

// File: rtl/btb_upd_fifo.sv
// Coalescing FIFO of pending BTB writes with a CAM-match overwrite port.
// Ports: clk/reset, upd_hold_i, wr_vld_i/wr_pc_i/wr_target_i (write request),
//        drain_fire_o, full_o, head_pc_o/head_target_o (combinational head entry).
module btb_upd_fifo
    import btb_update_queue_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int QPTR_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                upd_hold_i,
    input  logic                wr_vld_i,
    input  logic [PC_WIDTH-1:0] wr_pc_i,
    input  logic [PC_WIDTH-1:0] wr_target_i,
    output logic                drain_fire_o,
    output logic                full_o,
    output logic [PC_WIDTH-1:0] head_pc_o,
    output logic [PC_WIDTH-1:0] head_target_o
);

    upd_entry_t          entries_q [QDEPTH];
    upd_entry_t          entries_d [QDEPTH];
    logic [QPTR_W-1:0]   head_q, head_d;
    logic [QPTR_W-1:0]   tail_q, tail_d;
    logic [QPTR_W:0]     count_q, count_d;

    logic [QDEPTH-1:0]   match_vec;
    logic                match_any;
    logic [QPTR_W-1:0]   match_idx;
    logic                coalesce;
    logic                push;

    // CAM lookup over valid entries; at most one can match.
    always_comb begin
        match_vec = '0;
        match_idx = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            match_vec[i] = entries_q[i].valid && (entries_q[i].pc == wr_pc_i);
            if (match_vec[i]) match_idx = QPTR_W'(i);
        end
        match_any = |match_vec;
    end

    assign drain_fire_o = (count_q != '0) && !upd_hold_i;
    assign full_o       = (count_q == (QPTR_W+1)'(QDEPTH));

    // A hit on the head that is leaving this cycle would be lost if merged,
    // so that case falls back to a normal enqueue.
    assign coalesce = wr_vld_i && match_any && !(drain_fire_o && (match_idx == head_q));
    assign push     = wr_vld_i && !coalesce;

    always_comb begin
        entries_d = entries_q;
        // Pop clears first so a push into the same slot (full + drain) wins.
        if (drain_fire_o) entries_d[head_q].valid = 1'b0;
        if (coalesce)     entries_d[match_idx].target = wr_target_i;
        if (push)         entries_d[tail_q] = '{valid: 1'b1, pc: wr_pc_i, target: wr_target_i};
        head_d  = head_q + QPTR_W'(drain_fire_o);
        tail_d  = tail_q + QPTR_W'(push);
        count_d = count_q + (QPTR_W+1)'(push) - (QPTR_W+1)'(drain_fire_o);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) entries_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    assign head_pc_o     = entries_q[head_q].pc;
    assign head_target_o = entries_q[head_q].target;

endmodule

// File: rtl/btb_update_queue.sv
// Execute-side BTB update producer: checks predictions, redirects fetch, queues BTB writes.
// Ports: clk/reset, br (slave branch bus), upd_hold, BTB write port (is_req_pc/req_pc/predict_target),
//        redirect_valid/redirect_pc (registered, 1-cycle pulse), mispredict_cnt (saturating).
module btb_update_queue
    import btb_update_queue_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int QPTR_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    btb_update_queue_if.slave   br,
    input  logic                upd_hold,
    output logic                is_req_pc,
    output logic [PC_WIDTH-1:0] req_pc,
    output logic [PC_WIDTH-1:0] predict_target,
    output logic                redirect_valid,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic [CNT_W-1:0]    mispredict_cnt
);

    logic                drain_fire;
    logic                full;
    logic                accept;
    logic [PC_WIDTH-1:0] actual;
    logic                mispredict;
    logic                need_upd;

    logic                redirect_valid_q, redirect_valid_d;
    logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // A full queue can still accept when its head leaves this cycle.
    assign br.br_ready = !full || drain_fire;
    assign accept      = br.br_valid && br.br_ready;

    assign actual     = br.br_taken ? br.br_target : (br.br_pc + PC_WIDTH'(INST_BYTES));
    assign mispredict = (br.br_pred_pc != actual);
    // Not-taken never writes: the BTB has no way to invalidate an entry.
    assign need_upd   = br.br_taken && (!br.br_pred_hit || (br.br_pred_pc != br.br_target));

    btb_upd_fifo #(
        .QDEPTH (QDEPTH),
        .QPTR_W (QPTR_W)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .upd_hold_i    (upd_hold),
        .wr_vld_i      (accept && need_upd),
        .wr_pc_i       (br.br_pc),
        .wr_target_i   (br.br_target),
        .drain_fire_o  (drain_fire),
        .full_o        (full),
        .head_pc_o     (req_pc),
        .head_target_o (predict_target)
    );

    assign is_req_pc = drain_fire;

    always_comb begin
        redirect_valid_d = accept && mispredict;
        redirect_pc_d    = redirect_pc_q;
        cnt_d            = cnt_q;
        if (accept && mispredict) begin
            redirect_pc_d = actual;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            cnt_q            <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            cnt_q            <= cnt_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign mispredict_cnt = cnt_q;

endmodule
